// File: rtl/vip_stream_pkg.sv
// rtl/vip_stream_pkg.sv - shared mode encodings, reset dimensions and widths for the VIP stream adapter
package vip_stream_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'd0,
    MODE_CORE     = 2'd1,
    MODE_RAW      = 2'd2,
    MODE_CORE_ALT = 2'd3
  } mode_e;

  localparam logic [15:0] RESET_WIDTH      = 16'd640;
  localparam logic [15:0] RESET_HEIGHT     = 16'd480;
  localparam logic [3:0]  RESET_INTERLACED = 4'd0;

  localparam int DEFAULT_BITS_PER_SYMBOL  = 8;
  localparam int DEFAULT_SYMBOLS_PER_BEAT = 3;
  localparam int DEFAULT_DATA_W = DEFAULT_BITS_PER_SYMBOL * DEFAULT_SYMBOLS_PER_BEAT;

  function automatic logic uses_core(input mode_e m);
    return m != MODE_BYPASS;
  endfunction

endpackage

// File: rtl/vip_out_fifo.sv
// rtl/vip_out_fifo.sv - show-ahead output FIFO with occupancy and sticky overflow flag
module vip_out_fifo
  import vip_stream_pkg::*;
#(
  parameter int W     = DEFAULT_DATA_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/vip_stream_adapter.sv
// rtl/vip_stream_adapter.sv - mode-selectable adapter between the VIP wrapper and a FIFO-interfaced core
module vip_stream_adapter
  import vip_stream_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = DEFAULT_BITS_PER_SYMBOL,
  parameter int SYMBOLS_PER_BEAT = DEFAULT_SYMBOLS_PER_BEAT,
  parameter int CORE_OUT_BITS    = 8,
  parameter int OUT_DEPTH        = 8,
  parameter int CORE_RD_LAT      = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [1:0]                                mode,
  input  logic                                      stall_in,
  output logic                                      read,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
  input  logic                                      end_of_video,
  input  logic [15:0]                               width_in,
  input  logic [15:0]                               height_in,
  input  logic [3:0]                                interlaced_in,
  input  logic                                      vip_ctrl_valid,
  input  logic                                      stall_out,
  output logic                                      write,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
  output logic                                      end_of_video_out,
  output logic [15:0]                               width_out,
  output logic [15:0]                               height_out,
  output logic [3:0]                                interlaced_out,
  input  logic                                      vip_ctrl_busy,
  output logic                                      vip_ctrl_send,
  output logic                                      core_wr_en,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] core_din,
  input  logic                                      core_full,
  output logic                                      core_rd_en,
  input  logic [CORE_OUT_BITS-1:0]                  core_dout,
  input  logic                                      core_empty,
  output logic                                      frame_done,
  output logic                                      overflow_err
);

  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam int SW = (CORE_OUT_BITS < BITS_PER_SYMBOL) ? CORE_OUT_BITS : BITS_PER_SYMBOL;

  logic                       run;
  mode_e                      mode_active;
  logic                       core_sel;
  logic [CORE_RD_LAT-1:0]     rd_pipe;
  int                         inflight;
  logic                       credit;
  logic                       in_accept;
  logic                       out_xfer;
  logic                       hold_out;
  logic                       fifo_push;
  logic [DW-1:0]              fifo_din;
  logic [DW-1:0]              fifo_dout;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic [CW-1:0]              occ;
  logic                       fifo_ovf;
  logic [BITS_PER_SYMBOL-1:0] core_sym;
  logic [DW-1:0]              core_fmt;
  logic [31:0]                pix_cnt;
  logic [31:0]                frame_total;
  logic                       cnt_zero;
  logic                       frame_last;
  logic                       commit;
  logic                       mode_switch_ok;
  logic [15:0]                shadow_w;
  logic [15:0]                shadow_h;
  logic [3:0]                 shadow_il;
  logic                       pending_dims;
  logic                       pending_send;
  logic                       unused_eov_in;

  // Frame boundaries come from the local pixel counter, not from upstream.
  assign unused_eov_in = end_of_video;

  assign core_sel = uses_core(mode_active);

  always_comb begin
    inflight = 0;
    for (int i = 0; i < CORE_RD_LAT; i++) begin
      if (rd_pipe[i]) inflight = inflight + 1;
    end
  end

  // Every beat that may still land is reserved a slot, so a stalled sink never loses data.
  assign credit = (int'(occ) + inflight) < OUT_DEPTH;

  assign read       = run & (core_sel ? ~core_full : credit);
  assign in_accept  = read & ~stall_in;
  assign core_wr_en = core_sel & in_accept;
  assign core_din   = data_in;
  assign core_rd_en = run & core_sel & ~core_empty & credit;

  always_comb begin
    core_sym = '0;
    core_sym[SW-1:0] = core_dout[SW-1:0];
  end

  always_comb begin
    core_fmt = '0;
    if (mode_active == MODE_RAW) core_fmt[BITS_PER_SYMBOL-1:0] = core_sym;
    else                         core_fmt = {SYMBOLS_PER_BEAT{core_sym}};
  end

  assign fifo_push = core_sel ? rd_pipe[CORE_RD_LAT-1] : in_accept;
  assign fifo_din  = core_sel ? core_fmt : data_in;

  vip_out_fifo #(
    .W     (DW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .din      (fifo_din),
    .pop      (out_xfer),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (occ),
    .overflow (fifo_ovf)
  );

  assign frame_total = 32'(width_out) * 32'(height_out);
  assign cnt_zero    = (pix_cnt == 32'd0);
  assign frame_last  = (pix_cnt == frame_total - 32'd1);
  assign commit      = pending_dims & cnt_zero;

  // The first beat of a frame waits until new dimensions are committed and announced.
  assign hold_out = pending_send | commit;

  assign write            = ~fifo_empty & ~hold_out;
  assign out_xfer         = write & ~stall_out;
  assign data_out         = fifo_dout;
  assign end_of_video_out = write & frame_last;
  assign vip_ctrl_send    = pending_send & ~vip_ctrl_busy;
  assign overflow_err     = fifo_ovf;

  assign mode_switch_ok = cnt_zero & fifo_empty & (inflight == 0) & ~in_accept & ~core_rd_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run            <= 1'b0;
      mode_active    <= MODE_CORE;
      rd_pipe        <= '0;
      pix_cnt        <= 32'd0;
      frame_done     <= 1'b0;
      width_out      <= RESET_WIDTH;
      height_out     <= RESET_HEIGHT;
      interlaced_out <= RESET_INTERLACED;
      shadow_w       <= RESET_WIDTH;
      shadow_h       <= RESET_HEIGHT;
      shadow_il      <= RESET_INTERLACED;
      pending_dims   <= 1'b0;
      pending_send   <= 1'b0;
    end else begin
      run        <= 1'b1;
      rd_pipe[0] <= core_rd_en;
      for (int i = 1; i < CORE_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

      frame_done <= out_xfer & frame_last;
      if (out_xfer) pix_cnt <= frame_last ? 32'd0 : pix_cnt + 32'd1;

      if (mode_switch_ok) mode_active <= mode_e'(mode);

      if (vip_ctrl_send) pending_send <= 1'b0;
      if (commit) begin
        width_out      <= shadow_w;
        height_out     <= shadow_h;
        interlaced_out <= shadow_il;
        pending_dims   <= 1'b0;
        pending_send   <= 1'b1;
      end
      // A packet arriving on the commit cycle stays pending for the following frame.
      if (vip_ctrl_valid && width_in != 16'd0 && height_in != 16'd0) begin
        shadow_w     <= width_in;
        shadow_h     <= height_in;
        shadow_il    <= interlaced_in;
        pending_dims <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vip_stream_adapter.sv
// tb/tb_vip_stream_adapter.sv - directed self-checking bench for vip_stream_adapter
module tb_vip_stream_adapter;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        stall_in;
  logic        read;
  logic [23:0] data_in;
  logic        end_of_video;
  logic [15:0] width_in;
  logic [15:0] height_in;
  logic [3:0]  interlaced_in;
  logic        vip_ctrl_valid;
  logic        stall_out;
  logic        write;
  logic [23:0] data_out;
  logic        end_of_video_out;
  logic [15:0] width_out;
  logic [15:0] height_out;
  logic [3:0]  interlaced_out;
  logic        vip_ctrl_busy;
  logic        vip_ctrl_send;
  logic        core_wr_en;
  logic [23:0] core_din;
  logic        core_full;
  logic        core_rd_en;
  logic [7:0]  core_dout;
  logic        core_empty;
  logic        frame_done;
  logic        overflow_err;

  int n_cmp;
  int n_fail;

  logic [23:0] obs_data[$];
  logic        obs_eov[$];
  logic [15:0] obs_w[$];
  logic        obs_fd[$];
  int          fd_spurious;
  logic        timed_out;

  vip_stream_adapter dut (
    .clk(clk), .rst(rst), .mode(mode), .stall_in(stall_in), .read(read),
    .data_in(data_in), .end_of_video(end_of_video), .width_in(width_in),
    .height_in(height_in), .interlaced_in(interlaced_in), .vip_ctrl_valid(vip_ctrl_valid),
    .stall_out(stall_out), .write(write), .data_out(data_out),
    .end_of_video_out(end_of_video_out), .width_out(width_out), .height_out(height_out),
    .interlaced_out(interlaced_out), .vip_ctrl_busy(vip_ctrl_busy),
    .vip_ctrl_send(vip_ctrl_send), .core_wr_en(core_wr_en), .core_din(core_din),
    .core_full(core_full), .core_rd_en(core_rd_en), .core_dout(core_dout),
    .core_empty(core_empty), .frame_done(frame_done), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall_in = 1'b1; vip_ctrl_valid = 1'b0; stall_out = 1'b0;
    vip_ctrl_busy = 1'b0; core_full = 1'b0; core_empty = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic set_dims(input logic [15:0] w, input logic [15:0] h, output int sends);
    sends = 0;
    vip_ctrl_valid = 1'b1; width_in = w; height_in = h; interlaced_in = 4'd0;
    tick();
    vip_ctrl_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (vip_ctrl_send) sends++;
      tick();
    end
  endtask

  // Feeds n_in beats 0x010101*(k+1) and records outputs until n_exp transfers are seen.
  task automatic stream(input int n_in, input int n_exp, input int ctrl_at,
                        input int mode_at, input logic [1:0] mode_new);
    int   k = 0;
    logic acc;
    logic xfer;
    logic prev_eov = 1'b0;
    logic ctrl_done = 1'b0;
    obs_data.delete(); obs_eov.delete(); obs_w.delete(); obs_fd.delete();
    fd_spurious = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (obs_data.size() >= n_exp && !prev_eov) break;
      vip_ctrl_valid = 1'b0;
      if (ctrl_at >= 0 && !ctrl_done && obs_data.size() == ctrl_at) begin
        vip_ctrl_valid = 1'b1; width_in = 16'd8; height_in = 16'd1; ctrl_done = 1'b1;
      end
      if (mode_at >= 0 && obs_data.size() >= mode_at) mode = mode_new;
      stall_in = (k >= n_in);
      data_in  = 24'(32'h010101 * (k + 1));
      #1;
      acc  = read & ~stall_in;
      xfer = write & ~stall_out;
      if (prev_eov) obs_fd.push_back(frame_done);
      else if (frame_done) fd_spurious++;
      if (xfer) begin
        obs_data.push_back(data_out);
        obs_eov.push_back(end_of_video_out);
        obs_w.push_back(width_out);
      end
      prev_eov = xfer & end_of_video_out;
      tick();
      if (acc) k++;
    end
    vip_ctrl_valid = 1'b0;
    stall_in = 1'b1;
    timed_out = (obs_data.size() < n_exp);
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 2'd1; stall_in = 1'b0; stall_out = 1'b0; vip_ctrl_valid = 1'b0;
    vip_ctrl_busy = 1'b0; core_full = 1'b0; core_empty = 1'b0; core_dout = 8'h00;
    data_in = 24'h0; width_in = 16'd0; height_in = 16'd0; interlaced_in = 4'd0;
    end_of_video = 1'b0;
    tick(); tick();
    n_cmp++; if (read !== 1'b0) begin n_fail++; $display("FAIL reset_read got %0b want 0", read); end
    n_cmp++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %0b want 0", write); end
    n_cmp++; if (core_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_core_rd_en got %0b want 0", core_rd_en); end
    n_cmp++; if (core_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_core_wr_en got %0b want 0", core_wr_en); end
    n_cmp++; if (width_out !== 16'd640) begin n_fail++; $display("FAIL reset_width got %0d want 640", width_out); end
    n_cmp++; if (height_out !== 16'd480) begin n_fail++; $display("FAIL reset_height got %0d want 480", height_out); end
    n_cmp++; if (interlaced_out !== 4'd0) begin n_fail++; $display("FAIL reset_interlaced got %0d want 0", interlaced_out); end
    n_cmp++; if (vip_ctrl_send !== 1'b0) begin n_fail++; $display("FAIL reset_send got %0b want 0", vip_ctrl_send); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow_err); end
    rst = 1'b1; core_empty = 1'b1; stall_in = 1'b1;
  endtask

  task automatic test_bypass();
    int s;
    mode = 2'd0;
    do_reset();
    set_dims(16'd4, 16'd2, s);
    n_cmp++; if (s !== 1) begin n_fail++; $display("FAIL byp_send_count got %0d want 1", s); end
    n_cmp++; if (width_out !== 16'd4) begin n_fail++; $display("FAIL byp_width got %0d want 4", width_out); end
    n_cmp++; if (height_out !== 16'd2) begin n_fail++; $display("FAIL byp_height got %0d want 2", height_out); end
    stream(8, 8, -1, -1, 2'd0);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL byp_timeout got %0d beats want 8", obs_data.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs_data[i] !== 24'(32'h010101 * (i + 1))) begin
        n_fail++; $display("FAIL byp_data[%0d] got %06h want %06h", i, obs_data[i], 24'(32'h010101 * (i + 1)));
      end
      n_cmp++;
      if (obs_eov[i] !== (i == 7)) begin
        n_fail++; $display("FAIL byp_eov[%0d] got %0b want %0b", i, obs_eov[i], (i == 7));
      end
    end
    n_cmp++; if (obs_fd.size() !== 1 || obs_fd[0] !== 1'b1) begin n_fail++; $display("FAIL byp_frame_done got %0d samples want one pulse", obs_fd.size()); end
    n_cmp++; if (fd_spurious !== 0) begin n_fail++; $display("FAIL byp_frame_done_spurious got %0d want 0", fd_spurious); end
  endtask

  task automatic test_core_stall();
    int rds = 0;
    mode = 2'd1;
    do_reset();
    stall_out = 1'b1; core_dout = 8'h5A; core_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (core_rd_en) rds++;
      tick();
    end
    core_empty = 1'b1;
    n_cmp++; if (rds !== 8) begin n_fail++; $display("FAIL stall_rd_count got %0d want 8", rds); end
    n_cmp++; if (write !== 1'b1) begin n_fail++; $display("FAIL stall_write got %0b want 1", write); end
    stall_out = 1'b0;
    stream(0, 8, -1, -1, 2'd1);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got %0d beats want 8", obs_data.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs_data[i] !== 24'h5A5A5A) begin n_fail++; $display("FAIL stall_data[%0d] got %06h want 5a5a5a", i, obs_data[i]); end
    end
    n_cmp++; if (write !== 1'b0) begin n_fail++; $display("FAIL stall_drained got %0b want 0", write); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL stall_overflow got %0b want 0", overflow_err); end
  endtask

  task automatic test_raw_and_alt_mode();
    mode = 2'd2;
    do_reset();
    tick(); tick();
    core_dout = 8'hC3; core_empty = 1'b0; stall_out = 1'b1;
    #1;
    n_cmp++; if (core_rd_en !== 1'b1) begin n_fail++; $display("FAIL raw_rd_en got %0b want 1", core_rd_en); end
    tick();
    core_empty = 1'b1; stall_out = 1'b0;
    stream(0, 1, -1, -1, 2'd2);
    n_cmp++; if (obs_data[0] !== 24'h0000C3) begin n_fail++; $display("FAIL raw_data got %06h want 0000c3", obs_data[0]); end
    mode = 2'd3;
    do_reset();
    tick(); tick();
    core_dout = 8'h3C; core_empty = 1'b0; stall_out = 1'b1;
    tick();
    core_empty = 1'b1; stall_out = 1'b0;
    stream(0, 1, -1, -1, 2'd3);
    n_cmp++; if (obs_data[0] !== 24'h3C3C3C) begin n_fail++; $display("FAIL alt_data got %06h want 3c3c3c", obs_data[0]); end
  endtask

  task automatic test_ctrl_packet();
    int s;
    mode = 2'd0;
    do_reset();
    set_dims(16'd4, 16'd2, s);
    set_dims(16'd0, 16'd5, s);
    n_cmp++; if (s !== 0) begin n_fail++; $display("FAIL ctrl_zero_send got %0d want 0", s); end
    n_cmp++; if (height_out !== 16'd2) begin n_fail++; $display("FAIL ctrl_zero_height got %0d want 2", height_out); end
    vip_ctrl_busy = 1'b1;
    stream(8, 8, 3, -1, 2'd0);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL ctrl_timeout got %0d beats want 8", obs_data.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs_w[i] !== 16'd4) begin n_fail++; $display("FAIL ctrl_width_mid[%0d] got %0d want 4", i, obs_w[i]); end
    end
    n_cmp++; if (obs_eov[7] !== 1'b1) begin n_fail++; $display("FAIL ctrl_eov_last got %0b want 1", obs_eov[7]); end
    n_cmp++; if (width_out !== 16'd8) begin n_fail++; $display("FAIL ctrl_width_new got %0d want 8", width_out); end
    n_cmp++; if (height_out !== 16'd1) begin n_fail++; $display("FAIL ctrl_height_new got %0d want 1", height_out); end
    n_cmp++; if (vip_ctrl_send !== 1'b0) begin n_fail++; $display("FAIL ctrl_send_busy got %0b want 0", vip_ctrl_send); end
    stall_in = 1'b0; data_in = 24'hAAAAAA;
    tick();
    stall_in = 1'b1;
    tick(); tick();
    n_cmp++; if (write !== 1'b0) begin n_fail++; $display("FAIL ctrl_write_held got %0b want 0", write); end
    vip_ctrl_busy = 1'b0;
    #1;
    n_cmp++; if (vip_ctrl_send !== 1'b1) begin n_fail++; $display("FAIL ctrl_send_pulse got %0b want 1", vip_ctrl_send); end
    n_cmp++; if (write !== 1'b0) begin n_fail++; $display("FAIL ctrl_send_priority got %0b want 0", write); end
    tick();
    n_cmp++; if (vip_ctrl_send !== 1'b0) begin n_fail++; $display("FAIL ctrl_send_single got %0b want 0", vip_ctrl_send); end
    n_cmp++; if (write !== 1'b1 || data_out !== 24'hAAAAAA) begin n_fail++; $display("FAIL ctrl_first_beat got %0b/%06h want 1/aaaaaa", write, data_out); end
    tick();
  endtask

  task automatic test_mode_switch();
    int s;
    mode = 2'd0;
    do_reset();
    set_dims(16'd4, 16'd2, s);
    stream(8, 8, -1, 3, 2'd1);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL msw_timeout got %0d beats want 8", obs_data.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs_data[i] !== 24'(32'h010101 * (i + 1))) begin
        n_fail++; $display("FAIL msw_bypass[%0d] got %06h want %06h", i, obs_data[i], 24'(32'h010101 * (i + 1)));
      end
    end
    tick();
    stall_in = 1'b0; data_in = 24'h123456;
    #1;
    n_cmp++; if (core_wr_en !== 1'b1 || core_din !== 24'h123456) begin n_fail++; $display("FAIL msw_core_wr got %0b/%06h want 1/123456", core_wr_en, core_din); end
    core_full = 1'b1;
    #1;
    n_cmp++; if (read !== 1'b0 || core_wr_en !== 1'b0) begin n_fail++; $display("FAIL msw_core_full got %0b/%0b want 0/0", read, core_wr_en); end
    core_full = 1'b0; stall_in = 1'b1;
    tick();
    core_dout = 8'h11; core_empty = 1'b0; stall_out = 1'b1;
    #1;
    n_cmp++; if (core_rd_en !== 1'b1) begin n_fail++; $display("FAIL msw_core_rd got %0b want 1", core_rd_en); end
    tick(); tick();
    core_empty = 1'b1; stall_out = 1'b0;
    stream(0, 2, -1, -1, 2'd1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs_data[i] !== 24'h111111) begin n_fail++; $display("FAIL msw_core_data[%0d] got %06h want 111111", i, obs_data[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    int s;
    int k = 0;
    logic acc;
    mode = 2'd0;
    do_reset();
    set_dims(16'd4, 16'd2, s);
    stream(2, 2, -1, -1, 2'd0);
    stall_out = 1'b1;
    for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
      stall_in = 1'b0; data_in = 24'hF0F0F0;
      #1;
      acc = read;
      tick();
      if (acc) k++;
    end
    stall_in = 1'b1;
    n_cmp++; if (write !== 1'b1) begin n_fail++; $display("FAIL rmid_buffered got %0b want 1", write); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++; if (write !== 1'b0) begin n_fail++; $display("FAIL rmid_write got %0b want 0", write); end
    n_cmp++; if (width_out !== 16'd640 || height_out !== 16'd480) begin n_fail++; $display("FAIL rmid_dims got %0dx%0d want 640x480", width_out, height_out); end
    stall_out = 1'b0;
    set_dims(16'd2, 16'd1, s);
    stream(2, 2, -1, -1, 2'd0);
    n_cmp++; if (obs_eov[0] !== 1'b0 || obs_eov[1] !== 1'b1) begin n_fail++; $display("FAIL rmid_counter_restart got %0b%0b want 01", obs_eov[0], obs_eov[1]); end
    n_cmp++; if (obs_data[1] !== 24'h020202) begin n_fail++; $display("FAIL rmid_data got %06h want 020202", obs_data[1]); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_bypass();
    test_core_stall();
    test_raw_and_alt_mode();
    test_ctrl_packet();
    test_mode_switch();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vip_stream_adapter.md
Name: vip_stream_adapter

Overview:
- Parametrised successor to the single-purpose VIP algorithm wrapper.
- Sits between the VIP flow-control wrapper and any FIFO-interfaced processing core (e.g. canny_top).
- Adds mode selection, lossless output buffering under downstream stall, and frame-accurate end_of_video regeneration from a pixel counter.
- Control-packet dimensions are committed only at frame boundaries.

Parameters:
- BITS_PER_SYMBOL, 8, bits per colour symbol.
- SYMBOLS_PER_BEAT, 3, symbols per pixel beat.
- CORE_OUT_BITS, 8, width of the core output pixel.
- OUT_DEPTH, 8, output FIFO entries; power of two, at least 4.
- CORE_RD_LAT, 1, cycles from core_rd_en to valid core_dout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- mode  in  2  0 = bypass; 1 = core, replicate result to all symbols; 2 = core raw, result in symbol 0 and other symbols zero; 3 = treated as 1.
- stall_in  in  1  upstream has no data this cycle.
- read  out  1  adapter requests an input beat.
- data_in  in  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  input pixel.
- end_of_video  in  1  input end-of-frame flag; ignored, see Behaviour.
- width_in, height_in  in  16  decoded control-packet dimensions.
- interlaced_in  in  4  decoded interlace field.
- vip_ctrl_valid  in  1  decoded control packet present.
- stall_out  in  1  downstream not accepting.
- write  out  1  output beat valid.
- data_out  out  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  output pixel.
- end_of_video_out  out  1  last beat of frame.
- width_out, height_out  out  16  active dimensions.
- interlaced_out  out  4  active interlace field.
- vip_ctrl_busy  in  1  encoder busy.
- vip_ctrl_send  out  1  one-cycle request to emit a control packet.
- core_wr_en  out  1  push to core input FIFO.
- core_din  out  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  core input data.
- core_full  in  1  core input FIFO full.
- core_rd_en  out  1  pop from core output FIFO.
- core_dout  in  CORE_OUT_BITS  core output data.
- core_empty  in  1  core output FIFO empty.
- frame_done  out  1  one-cycle pulse after a frame's last beat transfers.
- overflow_err  out  1  sticky: push attempted into a full output FIFO.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - FIFO and counters cleared; mode_active = 1; nothing in flight.
  - width_out = 640, height_out = 480, interlaced_out = 0.
  - vip_ctrl_send, frame_done, overflow_err = 0.
  - read, write, core_wr_en, core_rd_en = 0.
  - Reset mid-frame discards all buffered beats. The core's own FIFOs are not flushed by this block.
- Transfers:
  - Input beat accepted when read & ~stall_in.
  - Output beat transferred when write & ~stall_out.
  - write = output FIFO non-empty. data_out is the show-ahead FIFO head and holds while stalled.
- Bypass mode:
  - read = credit available.
  - Accepted beat is pushed to the output FIFO next cycle; write is first possible at t+1.
  - core_wr_en = core_rd_en = 0.
- Core modes:
  - read = ~core_full. core_wr_en = accepted beat; core_din = data_in, combinational.
  - core_rd_en = ~core_empty & credit.
  - core_dout is captured CORE_RD_LAT cycles later, formatted per mode, and pushed.
- Credit: occupancy + in-flight reads < OUT_DEPTH. In-flight count saturates at CORE_RD_LAT. This guarantees no beat is lost under arbitrary stall_out.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- A push while full with no pop sets overflow_err; the beat is dropped. This is unreachable by design and is an assertion target.
- Pixel counter:
  - 32-bit, incremented per output transfer.
  - end_of_video_out = 1 when the counter equals width_out*height_out - 1. Product is computed in 32 bits.
  - On that transfer the counter wraps to 0 and frame_done pulses the next cycle.
- Control packets:
  - On vip_ctrl_valid with width_in and height_in both nonzero, shadow registers load and pending_dims is set. Zero dimensions are ignored.
  - Commit (shadow to outputs) happens only when the counter is 0 and no beat of the current frame has transferred. A packet received mid-frame waits for the wrap.
  - A commit sets pending_send.
  - vip_ctrl_send pulses for one cycle when pending_send & ~vip_ctrl_busy, and takes priority over the first output beat of the new frame: write is held 0 that cycle.
- Mode change: mode is sampled into mode_active only when counter = 0, FIFO empty and in-flight = 0. Otherwise the old mode continues.

Decomposition:
- Package vip_stream_pkg: mode encodings, reset dimensions (640/480), data width localparam.
- Sub-module vip_out_fifo: parametrised show-ahead FIFO with occupancy output, OUT_DEPTH entries.

Test Plan:
- Bypass, dims 4x2, 8 beats 0x010101..0x080808, stall_out = 0 → identical data out; end_of_video_out on beat 8 only; frame_done the following cycle.
- Mode 1, core returns 0x5A, stall_out high 20 cycles → core_rd_en stops at 8 outstanding; after release, all beats are 0x5A5A5A in order, none lost; overflow_err = 0.
- Mode 2, core_dout = 0xC3 → data_out = 0x0000C3.
- vip_ctrl_valid 8x1 sent at beat 3 of a 4x2 frame → width_out stays 4 until the wrap, then 8; one vip_ctrl_send pulse, deferred while vip_ctrl_busy = 1.
- Mode switched 0→1 mid-frame → bypass continues to frame end; core path active from the next frame.
- rst = 0 for one cycle with 5 beats buffered → write = 0 next cycle; counter restarts; dims return to 640x480.
